// File: rtl/j22_intc.sv
// j22_intc: priority interrupt controller in front of the J22 cpu core.
// Define J22_INTC_NMI_EN to add a non-maskable interrupt input (nmi_in).
module j22_intc #(
    parameter int         NSRC      = 8,
    parameter logic [7:0] VBASE_RST = 8'h40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
`ifdef J22_INTC_NMI_EN
    input  logic            nmi_in,
`endif
    output logic            intr_req,
    output logic [3:0]      intr_level,
    output logic [7:0]      intr_vec,
    input  logic            inta_ack,
    input  logic            reg_we,
    input  logic            reg_re,
    input  logic [3:0]      reg_addr,
    input  logic [7:0]      reg_wdata,
    output logic [7:0]      reg_rdata
);

    localparam logic [3:0] ADDR_PEND  = 4'h8;
    localparam logic [3:0] ADDR_VBASE = 4'h9;
    localparam logic [7:0] NMI_VEC    = 8'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [3:0]      lvl_q, lvl_d;
    logic [7:0]      vec_q, vec_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      vbase_q;
    logic [7:0]      rdata_q, rdata_d;

    logic [NSRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [NSRC-1:0] rise;
    logic [4:0]      ipr_q [NSRC];
    logic [NSRC-1:0] edge_pend_q, edge_pend_d;
    logic [NSRC-1:0] pend, elig, clr;
    logic            pend_wr;
    logic            ack_mask;

    logic            win_any;
    logic [3:0]      win_lvl;
    logic [2:0]      win_idx;
    logic [7:0]      win_vec;

    logic            top_any;
    logic [3:0]      top_lvl;
    logic [7:0]      top_vec;
    logic            top_higher;
    logic            pres_nmi;
    logic            pres_elig;

    // ------------------------------------------------------------------
    // Input synchronisers; sync2_q is the synchronised line, sync3_q the
    // delayed copy used for rising-edge detection.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~sync3_q;
    assign pend_wr  = reg_we && (reg_addr == ADDR_PEND);
    assign ack_mask = (state_q == S_REQ) && inta_ack && !pres_nmi;

    // Per-source pending/eligibility; a set on the same edge as a clear wins.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign clr[gi]         = (pend_wr && reg_wdata[gi]) ||
                                     (ack_mask && (idx_q == 3'(gi)));
            assign edge_pend_d[gi] = ipr_q[gi][4] &
                                     (rise[gi] | (edge_pend_q[gi] & ~clr[gi]));
            assign pend[gi]        = ipr_q[gi][4] ? edge_pend_q[gi] : sync2_q[gi];
            assign elig[gi]        = pend[gi] && (ipr_q[gi][3:0] != 4'd0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) begin
                ipr_q[i] <= '0;
            end
            edge_pend_q <= '0;
            vbase_q     <= VBASE_RST;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (reg_we && (reg_addr == 4'(i))) begin
                    ipr_q[i] <= reg_wdata[4:0];
                end
            end
            edge_pend_q <= edge_pend_d;
            if (reg_we && (reg_addr == ADDR_VBASE)) begin
                vbase_q <= reg_wdata;
            end
        end
    end

    // Highest level wins; strict compare keeps the lowest index on ties.
    always_comb begin
        win_any = 1'b0;
        win_lvl = 4'd0;
        win_idx = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (elig[i] && (ipr_q[i][3:0] > win_lvl)) begin
                win_any = 1'b1;
                win_lvl = ipr_q[i][3:0];
                win_idx = 3'(i);
            end
        end
    end

    assign win_vec = vbase_q + {5'd0, win_idx};

`ifdef J22_INTC_NMI_EN
    logic [2:0] nmi_sync_q;
    logic       nmi_pend_q;
    logic       nmi_sel_q, nmi_sel_d;
    logic       nmi_rise;

    assign nmi_rise = nmi_sync_q[1] & ~nmi_sync_q[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nmi_sync_q <= '0;
            nmi_pend_q <= 1'b0;
            nmi_sel_q  <= 1'b0;
        end else begin
            nmi_sync_q <= {nmi_sync_q[1:0], nmi_in};
            nmi_pend_q <= nmi_rise |
                          (nmi_pend_q & ~((state_q == S_REQ) && inta_ack && nmi_sel_q));
            nmi_sel_q  <= nmi_sel_d;
        end
    end

    assign pres_nmi   = nmi_sel_q;
    assign top_any    = nmi_pend_q | win_any;
    assign top_lvl    = nmi_pend_q ? 4'hF : win_lvl;
    assign top_vec    = nmi_pend_q ? NMI_VEC : win_vec;
    assign top_higher = nmi_pend_q ? !nmi_sel_q : (win_any && (win_lvl > lvl_q));
    assign pres_elig  = nmi_sel_q ? nmi_pend_q : elig[idx_q];
`else
    assign pres_nmi   = 1'b0;
    assign top_any    = win_any;
    assign top_lvl    = win_lvl;
    assign top_vec    = win_vec;
    assign top_higher = win_any && (win_lvl > lvl_q);
    assign pres_elig  = elig[idx_q];
`endif

    // ------------------------------------------------------------------
    // Request FSM. Ack is checked before withdrawal and preemption, so an
    // ack coinciding with a would-be update retires the registered idx.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        lvl_d   = lvl_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
`ifdef J22_INTC_NMI_EN
        nmi_sel_d = nmi_sel_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (top_any) begin
                    req_d   = 1'b1;
                    lvl_d   = top_lvl;
                    vec_d   = top_vec;
                    idx_d   = win_idx;
`ifdef J22_INTC_NMI_EN
                    nmi_sel_d = nmi_pend_q;
`endif
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (inta_ack) begin
                    req_d   = 1'b0;
                    lvl_d   = 4'd0;
                    vec_d   = 8'd0;
                    state_d = S_GAP;
                end else if (!pres_elig) begin
                    req_d   = 1'b0;
                    lvl_d   = 4'd0;
                    vec_d   = 8'd0;
                    state_d = S_IDLE;
                end else if (top_higher) begin
                    lvl_d   = top_lvl;
                    vec_d   = top_vec;
                    idx_d   = win_idx;
`ifdef J22_INTC_NMI_EN
                    nmi_sel_d = nmi_pend_q;
`endif
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                lvl_d   = 4'd0;
                vec_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Register read mux; PEND reflects the value before any same-cycle write.
    always_comb begin
        rdata_d = rdata_q;
        if (reg_re) begin
            rdata_d = 8'd0;
            if (reg_addr == ADDR_PEND) begin
                rdata_d[NSRC-1:0] = pend;
            end else if (reg_addr == ADDR_VBASE) begin
                rdata_d = vbase_q;
            end else begin
                for (int i = 0; i < NSRC; i++) begin
                    if (reg_addr == 4'(i)) begin
                        rdata_d = {3'd0, ipr_q[i]};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            lvl_q   <= 4'd0;
            vec_q   <= 8'd0;
            idx_q   <= 3'd0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lvl_q   <= lvl_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
        end
    end

    assign intr_req   = req_q;
    assign intr_level = lvl_q;
    assign intr_vec   = vec_q;
    assign reg_rdata  = rdata_q;

endmodule

// File: tb/tb_j22_intc.sv
// Directed bench for j22_intc: expected presentations are queued when the
// interrupt is raised and compared when the controller asserts/updates them.
module tb_j22_intc;

    localparam int NSRC = 8;

    logic            clk;
    logic            rst;
    logic [NSRC-1:0] irq_in;
`ifdef J22_INTC_NMI_EN
    logic            nmi_in;
`endif
    logic            intr_req;
    logic [3:0]      intr_level;
    logic [7:0]      intr_vec;
    logic            inta_ack;
    logic            reg_we;
    logic            reg_re;
    logic [3:0]      reg_addr;
    logic [7:0]      reg_wdata;
    logic [7:0]      reg_rdata;

    j22_intc #(.NSRC(NSRC), .VBASE_RST(8'h40)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
`ifdef J22_INTC_NMI_EN
        .nmi_in     (nmi_in),
`endif
        .intr_req   (intr_req),
        .intr_level (intr_level),
        .intr_vec   (intr_vec),
        .inta_ack   (inta_ack),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] lvl;
        logic [7:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] l, input logic [7:0] v);
        exp_t e;
        e.lvl = l;
        e.vec = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_req"}, 32'(intr_req), 32'd1);
            chk({tag, "_lvl"}, 32'(intr_level), 32'(e.lvl));
            chk({tag, "_vec"}, 32'(intr_vec), 32'(e.vec));
            $display("[TB] present %s lvl=%h vec=%h", tag, intr_level, intr_vec);
        end
    endtask

    task automatic wait_present(input string tag, input int maxc, output int took);
        took = 0;
        while (intr_req !== 1'b1 && took < maxc) begin
            tick();
            took++;
        end
        pop_cmp(tag);
    endtask

    // Waits for the presented level to move away from old_lvl while req stays up.
    task automatic wait_update(input string tag, input logic [3:0] old_lvl, output int took);
        bit dropped;
        dropped = 1'b0;
        took    = 0;
        do begin
            tick();
            took++;
            if (intr_req !== 1'b1) dropped = 1'b1;
        end while (intr_level === old_lvl && took < 8);
        chk({tag, "_nodrop"}, 32'(dropped), 32'd0);
        pop_cmp(tag);
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_we    = 1'b0;
        $display("[TB] write addr=%h data=%h", a, d);
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
        reg_re   = 1'b1;
        reg_addr = a;
        tick();
        reg_re   = 1'b0;
        d        = reg_rdata;
        $display("[TB] read  addr=%h data=%h", a, d);
    endtask

    task automatic ack();
        inta_ack = 1'b1;
        tick();
        inta_ack = 1'b0;
        $display("[TB] ack");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         took;

        rst       = 1'b0;
        irq_in    = '0;
`ifdef J22_INTC_NMI_EN
        nmi_in    = 1'b0;
`endif
        inta_ack  = 1'b0;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        reg_addr  = 4'd0;
        reg_wdata = 8'd0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Reset state
        chk("rst_req", 32'(intr_req), 32'd0);
        chk("rst_lvl", 32'(intr_level), 32'd0);
        chk("rst_vec", 32'(intr_vec), 32'd0);
        chk("rst_rdata", 32'(reg_rdata), 32'd0);
        reg_read(4'h9, rd);
        chk("rst_vbase", 32'(rd), 32'h40);
        reg_read(4'h8, rd);
        chk("rst_pend", 32'(rd), 32'h00);
        reg_read(4'h3, rd);
        chk("rst_ipr3", 32'(rd), 32'h00);

        // Edge source 3, latency 4 clk, ack then GAP
        reg_write(4'h3, 8'h15);
        irq_in[3] = 1'b1;
        push_exp(4'd5, 8'h43);
        wait_present("edge3", 8, took);
        chk("edge3_latency", 32'(took), 32'd4);
        irq_in[3] = 1'b0;
        ack();
        chk("edge3_gap_req", 32'(intr_req), 32'd0);
        reg_read(4'h8, rd);
        chk("edge3_pend_clr", 32'(rd), 32'h00);
        chk("edge3_idle_req", 32'(intr_req), 32'd0);

        // Level sources 1 and 6 tie at level 7: lowest index wins
        reg_write(4'h3, 8'h00);
        reg_write(4'h1, 8'h07);
        reg_write(4'h6, 8'h07);
        irq_in[1] = 1'b1;
        irq_in[6] = 1'b1;
        push_exp(4'd7, 8'h41);
        wait_present("tie", 8, took);
        chk("tie_latency", 32'(took), 32'd3);
        ack();
        chk("tie_gap_req", 32'(intr_req), 32'd0);
        push_exp(4'd7, 8'h41);
        wait_present("tie_again", 4, took);
        chk("tie_again_delay", 32'(took), 32'd2);

        // Level line 1 drops before ack: withdrawn, then source 6 presented
        irq_in[1] = 1'b0;
        tick();
        tick();
        chk("lvl_drop_hold", 32'(intr_req), 32'd1);
        tick();
        chk("lvl_drop_req", 32'(intr_req), 32'd0);
        push_exp(4'd7, 8'h46);
        wait_present("src6", 4, took);
        chk("src6_delay", 32'(took), 32'd1);
        irq_in[6] = 1'b0;
        repeat (3) tick();
        chk("src6_drop_req", 32'(intr_req), 32'd0);
        reg_write(4'h1, 8'h00);
        reg_write(4'h6, 8'h00);

        // Preemption: source 2 at level 3, source 5 at level 9
        reg_write(4'h2, 8'h13);
        reg_write(4'h5, 8'h19);
        irq_in[2] = 1'b1;
        push_exp(4'd3, 8'h42);
        wait_present("src2", 8, took);
        irq_in[2] = 1'b0;
        irq_in[5] = 1'b1;
        push_exp(4'd9, 8'h45);
        wait_update("preempt5", 4'd3, took);
        chk("preempt5_latency", 32'(took), 32'd4);
        ack();
        chk("preempt5_gap_req", 32'(intr_req), 32'd0);
        push_exp(4'd3, 8'h42);
        wait_present("src2_again", 4, took);
        chk("src2_again_delay", 32'(took), 32'd2);
        reg_read(4'h8, rd);
        chk("preempt_pend", 32'(rd), 32'h04);
        ack();
        reg_read(4'h8, rd);
        chk("preempt_pend_clr", 32'(rd), 32'h00);
        irq_in[5] = 1'b0;
        repeat (3) tick();

        // PEND write-1-to-clear withdraws the presented edge source
        reg_write(4'h3, 8'h15);
        irq_in[3] = 1'b1;
        push_exp(4'd5, 8'h43);
        wait_present("w1c", 8, took);
        reg_write(4'h8, 8'h08);
        chk("w1c_hold", 32'(intr_req), 32'd1);
        tick();
        chk("w1c_req", 32'(intr_req), 32'd0);
        reg_read(4'h8, rd);
        chk("w1c_pend", 32'(rd), 32'h00);
        irq_in[3] = 1'b0;
        repeat (3) tick();

        // Set and clear in the same cycle: set wins
        irq_in[3] = 1'b1;
        tick();
        tick();
        reg_write(4'h8, 8'h08);
        reg_read(4'h8, rd);
        chk("setclr_pend", 32'(rd), 32'h08);
        push_exp(4'd5, 8'h43);
        wait_present("setclr", 4, took);
        ack();
        irq_in[3] = 1'b0;
        repeat (3) tick();

        // Vector wrap-around
        reg_write(4'h9, 8'hFE);
        irq_in[3] = 1'b1;
        push_exp(4'd5, 8'h01);
        wait_present("wrap", 8, took);
        ack();
        irq_in[3] = 1'b0;
        reg_write(4'h9, 8'h40);
        repeat (2) tick();

        // Level-0 source pends but is not eligible; ack outside REQ ignored
        reg_write(4'h4, 8'h10);
        irq_in[4] = 1'b1;
        repeat (5) tick();
        chk("lvl0_req", 32'(intr_req), 32'd0);
        ack();
        reg_read(4'h8, rd);
        chk("lvl0_pend", 32'(rd), 32'h10);
        reg_write(4'h4, 8'h11);
        push_exp(4'd1, 8'h44);
        wait_present("src4", 4, took);
        reg_write(4'h8, 8'h10);
        tick();
        chk("src4_w1c_req", 32'(intr_req), 32'd0);
        irq_in[4] = 1'b0;

        // Unmapped address and IPR readback
        reg_write(4'hA, 8'hFF);
        reg_read(4'hA, rd);
        chk("unmapped_rd", 32'(rd), 32'h00);
        reg_read(4'h5, rd);
        chk("ipr5_rd", 32'(rd), 32'h19);

`ifdef J22_INTC_NMI_EN
        // NMI preempts level-4 source 0, then source 0 returns after GAP
        reg_write(4'h0, 8'h04);
        irq_in[0] = 1'b1;
        push_exp(4'd4, 8'h40);
        wait_present("src0", 8, took);
        nmi_in = 1'b1;
        push_exp(4'hF, 8'h0B);
        wait_update("nmi", 4'd4, took);
        chk("nmi_latency", 32'(took), 32'd4);
        ack();
        chk("nmi_gap_req", 32'(intr_req), 32'd0);
        push_exp(4'd4, 8'h40);
        wait_present("src0_again", 4, took);
        chk("src0_again_delay", 32'(took), 32'd2);
        nmi_in = 1'b0;
        irq_in[0] = 1'b0;
        repeat (4) tick();
        reg_write(4'h0, 8'h00);
`endif

        // Asynchronous reset mid-REQ
        reg_write(4'h9, 8'h80);
        reg_write(4'h1, 8'h07);
        irq_in[1] = 1'b1;
        push_exp(4'd7, 8'h81);
        wait_present("pre_rst", 8, took);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", 32'(intr_req), 32'd0);
        chk("arst_lvl", 32'(intr_level), 32'd0);
        chk("arst_vec", 32'(intr_vec), 32'd0);
        irq_in[1] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        reg_read(4'h9, rd);
        chk("arst_vbase", 32'(rd), 32'h40);
        reg_read(4'h1, rd);
        chk("arst_ipr1", 32'(rd), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
